// File: rtl/cxu_li_l1_adapter_pkg.sv
// Shared types and helpers for the CXU LI-to-L1 adapter slice.
package cxu_li_l1_adapter_pkg;

  typedef enum logic [2:0] {
    CXU_OK         = 3'd0,
    CXU_ERR_FUNC   = 3'd1,
    CXU_ERR_STATE  = 3'd2,
    CXU_ERR_CUSTOM = 3'd3
  } cxu_status_t;

  localparam int CXU_STATUS_W = $bits(cxu_status_t);

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/cxu_li_l1_adapter_if.sv
// Latency-insensitive CXU request/response bundle.
interface cxu_li_l1_adapter_if #(
  parameter int CXU_ID_W   = 1,
  parameter int STATE_ID_W = 1,
  parameter int FUNC_ID_W  = 10,
  parameter int DATA_W     = 32
) ();
  import cxu_li_l1_adapter_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [CXU_ID_W-1:0]   req_cxu;
  logic [STATE_ID_W-1:0] req_state;
  logic [FUNC_ID_W-1:0]  req_func;
  logic [DATA_W-1:0]     req_data0;
  logic [DATA_W-1:0]     req_data1;
  logic                  resp_valid;
  logic                  resp_ready;
  cxu_status_t           resp_status;
  logic [DATA_W-1:0]     resp_data;

  modport master (
    output req_valid, req_cxu, req_state, req_func, req_data0, req_data1, resp_ready,
    input  req_ready, resp_valid, resp_status, resp_data
  );

  modport slave (
    input  req_valid, req_cxu, req_state, req_func, req_data0, req_data1, resp_ready,
    output req_ready, resp_valid, resp_status, resp_data
  );
endinterface

// File: rtl/cxu_li_l1_adapter_resp_fifo.sv
// Response FIFO: async-reset pointers, modulo-DEPTH wrap, no bypass.
module cxu_li_l1_adapter_resp_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents are meaningless until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/cxu_li_l1_adapter.sv
// Puts a fixed-latency L1 CXU behind a valid/ready LI interface. Requests are
// issued to L1 the cycle they are accepted; responses land in a FIFO sized by
// a credit counter so consumer backpressure never loses a result.
module cxu_li_l1_adapter
  import cxu_li_l1_adapter_pkg::*;
#(
  parameter int CXU_N_CXUS    = 1,
  parameter int CXU_N_STATES  = 1,
  parameter int CXU_LATENCY   = 0,
  parameter int CXU_FUNC_ID_W = 10,
  parameter int CXU_DATA_W    = 32,
  parameter int DEPTH         = CXU_LATENCY + 2,
  localparam int CXU_STATE_ID_W = max_i(1, $clog2(CXU_N_STATES)),
  localparam int CXU_CXU_ID_W   = max_i(1, $clog2(CXU_N_CXUS))
) (
  input  logic                      clk,
  input  logic                      rst,
  cxu_li_l1_adapter_if.slave        li,
  output logic                      l1_clk_en,
  output logic                      l1_req_valid,
  output logic [CXU_CXU_ID_W-1:0]   l1_req_cxu,
  output logic [CXU_STATE_ID_W-1:0] l1_req_state,
  output logic [CXU_FUNC_ID_W-1:0]  l1_req_func,
  output logic [CXU_DATA_W-1:0]     l1_req_data0,
  output logic [CXU_DATA_W-1:0]     l1_req_data1,
  input  logic                      l1_resp_valid,
  input  cxu_status_t               l1_resp_status,
  input  logic [CXU_DATA_W-1:0]     l1_resp_data,
  output logic                      proto_err
);
  localparam int UW = $clog2(DEPTH + 1);
  localparam int FW = CXU_STATUS_W + CXU_DATA_W;

  if (DEPTH < 1) begin : g_bad_depth
    $error("cxu_li_l1_adapter: DEPTH must be at least 1");
  end
  if (CXU_LATENCY < 0 || CXU_LATENCY > 15) begin : g_bad_latency
    $error("cxu_li_l1_adapter: CXU_LATENCY must be within 0..15");
  end

  logic [UW-1:0] used;
  logic          accept, pop, exp_v;
  logic          fifo_empty, unused_fifo_full;
  logic [FW-1:0] fifo_dout;

  // Credit gate looks only at registered state, never at resp_ready.
  assign li.req_ready = !rst && (used < UW'(DEPTH));
  assign accept       = li.req_valid && li.req_ready;
  assign pop          = li.resp_valid && li.resp_ready;

  // Request forwarded combinationally; a bad cxu id is left to the CXU.
  assign l1_clk_en    = 1'b1;
  assign l1_req_valid = accept;
  assign l1_req_cxu   = li.req_cxu;
  assign l1_req_state = li.req_state;
  assign l1_req_func  = li.req_func;
  assign l1_req_data0 = li.req_data0;
  assign l1_req_data1 = li.req_data1;

  // exp_v marks the cycle an L1 response is due for an earlier accept.
  if (CXU_LATENCY == 0) begin : g_nopipe
    assign exp_v = accept;
  end else begin : g_pipe
    logic [CXU_LATENCY-1:0] vld_pipe;
    // Expect shift register, cleared asynchronously with the CXU pipeline.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_pipe <= '0;
      end else begin
        vld_pipe[0] <= accept;
        for (int i = 1; i < CXU_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
    end
    assign exp_v = vld_pipe[CXU_LATENCY-1];
  end

  // Outstanding-credit counter: accepted but not yet popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      used <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase
    end
  end

  // Sticky flag for any L1 response that disagrees with the expect pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           proto_err <= 1'b0;
    else if (l1_resp_valid != exp_v)   proto_err <= 1'b1;
  end

  // Captured on exp_v alone; an unexpected response is simply dropped.
  cxu_li_l1_adapter_resp_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (exp_v),
    .pop   (pop),
    .full  (unused_fifo_full),
    .empty (fifo_empty),
    .din   ({l1_resp_status, l1_resp_data}),
    .dout  (fifo_dout)
  );

  assign li.resp_valid  = !fifo_empty;
  assign li.resp_status = cxu_status_t'(fifo_dout[FW-1 -: CXU_STATUS_W]);
  assign li.resp_data   = fifo_dout[CXU_DATA_W-1:0];
endmodule

// File: tb/tb_cxu_li_l1_adapter.sv
// Bench for cxu_li_l1_adapter with a 2-cycle dot-product CXU model downstream.
module tb_cxu_li_l1_adapter;
  import cxu_li_l1_adapter_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cxu_li_l1_adapter_if #(.CXU_ID_W(1), .STATE_ID_W(1), .FUNC_ID_W(10), .DATA_W(32)) li ();

  logic        l1_clk_en, l1_req_valid, l1_resp_valid, proto_err;
  logic [0:0]  l1_req_cxu, l1_req_state;
  logic [9:0]  l1_req_func;
  logic [31:0] l1_req_data0, l1_req_data1, l1_resp_data;
  cxu_status_t l1_resp_status;
  logic        inj = 1'b0;

  cxu_li_l1_adapter #(.CXU_N_CXUS(1), .CXU_N_STATES(1), .CXU_LATENCY(LAT),
                      .CXU_FUNC_ID_W(10), .CXU_DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .li(li),
    .l1_clk_en(l1_clk_en), .l1_req_valid(l1_req_valid), .l1_req_cxu(l1_req_cxu),
    .l1_req_state(l1_req_state), .l1_req_func(l1_req_func),
    .l1_req_data0(l1_req_data0), .l1_req_data1(l1_req_data1),
    .l1_resp_valid(l1_resp_valid), .l1_resp_status(l1_resp_status),
    .l1_resp_data(l1_resp_data), .proto_err(proto_err)
  );

  // CXU behaviour: func 0 = byte-wise dot product, else XOR; func > 1 flags error.
  function automatic logic [31:0] ref_data(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b);
    int s;
    s = 0;
    if (f != 10'd0) return a ^ b;
    for (int i = 0; i < 4; i++) s += int'(a[8*i +: 8]) * int'(b[8*i +: 8]);
    return 32'(s);
  endfunction

  function automatic cxu_status_t ref_status(input logic [9:0] f);
    return (f > 10'd1) ? CXU_ERR_FUNC : CXU_OK;
  endfunction

  // Downstream fixed-latency CXU, sharing rst with the adapter.
  logic [1:0]  cv;
  logic [31:0] cd [2];
  cxu_status_t cs [2];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cv <= '0;
    end else begin
      cv    <= {cv[0], l1_req_valid};
      cd[0] <= ref_data(l1_req_func, l1_req_data0, l1_req_data1);
      cd[1] <= cd[0];
      cs[0] <= ref_status(l1_req_func);
      cs[1] <= cs[0];
    end
  end
  assign l1_resp_valid  = cv[1] | inj;
  assign l1_resp_data   = cd[1];
  assign l1_resp_status = cs[1];

  // Reference: in-order queue of expected responses with the first cycle each is visible.
  typedef struct {
    int          rdy;
    logic [31:0] d;
    cxu_status_t st;
  } exp_t;
  exp_t q[$];
  int   m_used = 0;
  bit   m_pe   = 1'b0;
  int   cyc    = 0;
  int   ntests = 0;
  int   nfail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    ntests++;
    assert (got === expv) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, expv);
    end
  endtask

  // One clock cycle: drive at negedge, check, then advance the model at posedge.
  task automatic step(input bit rv, input bit rr, input logic [9:0] f,
                      input logic [31:0] a, input logic [31:0] b, input bit inj_i,
                      output bit acc);
    bit exp_rdy, exp_rv, pop;
    exp_t e;
    @(negedge clk);
    li.req_valid = rv; li.resp_ready = rr; li.req_func = f;
    li.req_data0 = a;  li.req_data1 = b; inj = inj_i;
    #1;
    exp_rdy = (m_used < DEPTH);
    exp_rv  = (q.size() > 0) && (q[0].rdy <= cyc);
    acc     = rv && exp_rdy;
    pop     = exp_rv && rr;
    chk("req_ready", 32'(li.req_ready), 32'(exp_rdy));
    chk("resp_valid", 32'(li.resp_valid), 32'(exp_rv));
    chk("l1_req_valid", 32'(l1_req_valid), 32'(acc));
    chk("proto_err", 32'(proto_err), 32'(m_pe));
    chk("used_bound", 32'(dut.used <= 3'(DEPTH)), 32'd1);
    if (exp_rv) begin
      chk("resp_data", li.resp_data, q[0].d);
      chk("resp_status", 32'(li.resp_status), 32'(q[0].st));
    end
    if (acc) chk("l1_req_data1", l1_req_data1, b);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) begin
      e.rdy = cyc + LAT + 1; e.d = ref_data(f, a, b); e.st = ref_status(f);
      q.push_back(e);
    end
    m_used = m_used + int'(acc) - int'(pop);
    if (inj_i) m_pe = 1'b1;
    cyc++;
  endtask

  task automatic idle(input bit rr, input int n);
    bit acc;
    repeat (n) step(1'b0, rr, 10'd0, 32'd0, 32'd0, 1'b0, acc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete(); m_used = 0; m_pe = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit acc;
    int nacc;
    li.req_valid = 1'b0; li.resp_ready = 1'b0; li.req_cxu = '0; li.req_state = '0;
    li.req_func = '0; li.req_data0 = '0; li.req_data1 = '0;

    // Reset state
    #3;
    chk("rst_req_ready", 32'(li.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(li.resp_valid), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    chk("l1_clk_en", 32'(l1_clk_en), 32'd1);
    do_reset();

    // Back-to-back streaming of dot products, expecting 8 with no bubbles
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 10'd0, 32'h01010101, 32'h02020202, 1'b0, acc);
    idle(1'b1, 6);

    // Backpressure: 6 offered, 4 accepted
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 10'd1, 32'(i * 17), 32'h5a5a0000 + 32'(i), 1'b0, acc);
      nacc += int'(acc);
    end
    chk("bp_accepted", 32'(nacc), 32'd4);
    // Accept offered while popping at used=4: blocked now, allowed next cycle
    step(1'b1, 1'b1, 10'd0, 32'h03030303, 32'h01020304, 1'b0, acc);
    chk("full_pop_blocked", 32'(acc), 32'd0);
    step(1'b1, 1'b1, 10'd0, 32'h03030303, 32'h01020304, 1'b0, acc);
    chk("credit_returned", 32'(acc), 32'd1);
    idle(1'b1, 8);

    // Randomized traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 10'($urandom_range(0, 3)),
           $urandom, $urandom, 1'b0, acc);
    idle(1'b1, 10);

    // Reset mid-flight with 3 requests outstanding
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'd0, $urandom, $urandom, 1'b0, acc);
    idle(1'b0, 3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_resp_valid", 32'(li.resp_valid), 32'd0);
    chk("midrst_req_ready", 32'(li.req_ready), 32'd0);
    do_reset();
    #1;
    chk("postrst_used", 32'(dut.used), 32'd0);
    chk("postrst_req_ready", 32'(li.req_ready), 32'd1);
    chk("postrst_proto_err", 32'(proto_err), 32'd0);
    idle(1'b1, 2);

    // Protocol error: spurious L1 response, nothing outstanding
    step(1'b0, 1'b1, 10'd0, 32'd0, 32'd0, 1'b1, acc);
    idle(1'b1, 4);
    chk("pe_no_push_used", 32'(dut.used), 32'd0);
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 3)),
           $urandom, $urandom, 1'b0, acc);
    idle(1'b1, 8);
    do_reset();
    #1;
    chk("pe_cleared", 32'(proto_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
